// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: T-state sequencer and opcode decoder driving register load/bus strobes.
// Optional SEQ_EARLY_END_EN: return to T0 right after an instruction's last active step.
module cpu_step_sequencer #(
    parameter int NSTEPS = 6,
    parameter int OP_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] ir_op,
    input  logic            cf,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_en,
    output logic            ram_out,
    output logic            ir_en,
    output logic            ir_out,
    output logic            a_en,
    output logic            a_out,
    output logic            b_en,
    output logic            alu_out,
    output logic            alu_sub,
    output logic            flags_en,
    output logic            out_en,
    output logic [2:0]      step,
    output logic            halted
);
    logic [2:0] step_nxt;
    logic       halted_nxt, last, act;
    logic       t0, t1, t2, t3, t4;
    logic       is_lda, is_add, is_sub, is_ldi, is_jmp, is_jc, is_out, is_hlt;

    assign t0 = step == 3'd0;
    assign t1 = step == 3'd1;
    assign t2 = step == 3'd2;
    assign t3 = step == 3'd3;
    assign t4 = step == 3'd4;
    assign is_lda = ir_op == OP_W'(4'h1);
    assign is_add = ir_op == OP_W'(4'h2);
    assign is_sub = ir_op == OP_W'(4'h3);
    assign is_ldi = ir_op == OP_W'(4'h4);
    assign is_jmp = ir_op == OP_W'(4'h6);
    assign is_jc  = ir_op == OP_W'(4'h7);
    assign is_out = ir_op == OP_W'(4'hE);
    assign is_hlt = ir_op == OP_W'(4'hF);
    // Controls are held low during reset and after halt, regardless of step.
    assign act = rst && !halted;

`ifdef SEQ_EARLY_END_EN
    assign last = step == 3'(NSTEPS - 1)
               || step == (is_lda ? 3'd3 : (is_add || is_sub) ? 3'd4 : 3'd2);
`else
    assign last = step == 3'(NSTEPS - 1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
        end
    end

    // The halting edge leaves step parked at T2.
    always_comb begin
        halted_nxt = halted || (run && t2 && is_hlt);
        step_nxt   = (halted_nxt || !run) ? step : last ? 3'd0 : step + 3'd1;
    end

    always_comb begin
        pc_out   = act && t0;
        pc_inc   = act && t1;
        ir_en    = act && t1;
        pc_load  = act && t2 && (is_jmp || (is_jc && cf));
        mar_en   = act && (t0 || (t2 && (is_lda || is_add || is_sub)));
        ram_out  = act && (t1 || (t3 && (is_lda || is_add || is_sub)));
        ir_out   = act && t2 && (is_lda || is_add || is_sub || is_ldi || is_jmp || (is_jc && cf));
        a_en     = act && ((t2 && is_ldi) || (t3 && is_lda) || (t4 && (is_add || is_sub)));
        a_out    = act && t2 && is_out;
        out_en   = act && t2 && is_out;
        b_en     = act && t3 && (is_add || is_sub);
        alu_out  = act && t4 && (is_add || is_sub);
        flags_en = act && t4 && (is_add || is_sub);
        alu_sub  = act && is_sub && (t3 || t4);
    end
endmodule
